restoring_div_seq: RTL and testbench

Iterative restoring divider that computes one quotient bit per clock using a single row of ripple-borrow subtractor cells. The block sits directly upstream of the subtractor-cell array and drives it: each cycle it supplies the shifted partial remainder and the divisor, then uses the row's final borrow as the restore select. A start/done handshake brackets each division, and results stay valid until the next start.

---
 rtl/restoring_div_pkg.sv | 9 +
 rtl/subtractor_row.sv | 25 ++
 rtl/restoring_div_seq.sv | 85 ++++++++
 tb/tb_restoring_div_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/restoring_div_pkg.sv
// restoring_div_pkg: shared FSM state type, default operand width and step-counter sizing
package restoring_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/subtractor_row.sv
// subtractor_row: WIDTH+1 ripple-borrow cells; the final borrow drives every cell's sel to restore a
module subtractor_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  output logic [WIDTH:0] o_y,
  output logic           o_borrow
);
  logic [WIDTH:0] w_d;
  always_comb begin
    logic bw;
    w_d = '0;
    bw = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      w_d[i] = i_a[i] ^ i_b[i] ^ bw;
      bw = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & bw);
    end
    o_borrow = bw;
  end
  // sel sits after the borrow chain, so the final borrow never feeds back into it
  for (genvar c = 0; c <= WIDTH; c++) begin : g_cell
    assign o_y[c] = o_borrow ? i_a[c] : w_d[c];
  end
endmodule

// File: rtl/restoring_div_seq.sv
// restoring_div_seq: sequential restoring divider, one quotient bit per clock via subtractor_row.
// Define RESTORING_DIV_ZERO_CHECK_EN to short-circuit divide-by-zero into a one-cycle result.
module restoring_div_seq
  import restoring_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_w(WIDTH);
`ifdef RESTORING_DIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif
  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [WIDTH:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic           r_busy;
  logic           r_done;
  logic           r_dbz;
  logic [WIDTH:0] w_s;
  logic [WIDTH:0] w_y;
  logic           w_b;
  logic           w_skip;
  assign w_s    = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_skip = ZC && (divisor == '0);
  subtractor_row #(.WIDTH(WIDTH)) u_row (
    .i_a      (w_s),
    .i_b      ({1'b0, r_d}),
    .o_y      (w_y),
    .o_borrow (w_b)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else if (r_state != RUN && start) begin
      r_d     <= divisor;
      r_p     <= w_skip ? {1'b0, dividend} : '0;
      r_q     <= w_skip ? '1 : dividend;
      r_cnt   <= CW'(WIDTH);
      r_dbz   <= w_skip;
      r_state <= w_skip ? DONE : RUN;
      r_busy  <= !w_skip;
      r_done  <= w_skip;
    end else if (r_state == RUN) begin
      r_p   <= w_y;
      r_q   <= {r_q[WIDTH-2:0], ~w_b};
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end else begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end
  end
  // P stays below the divisor after every step, so its extra top bit never survives a cycle
  assert property (@(posedge clk) disable iff (rst) !r_p[WIDTH]);
  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_q;
  assign remainder   = r_p[WIDTH-1:0];
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_restoring_div_seq.sv
// tb_restoring_div_seq: directed and randomized checks of restoring_div_seq against an arithmetic model
module tb_restoring_div_seq;
  localparam int W = 8;
`ifdef RESTORING_DIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic busy;
  logic done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic div_by_zero;
  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  restoring_div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // model: a division occupies W cycles (0 for a short-circuited zero divisor), results from / and %
  int m_rem = 0;
  logic m_done = 1'b0;
  logic m_dbz = 1'b0;
  logic m_ok = 1'b0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  logic [W-1:0] p_q;
  logic [W-1:0] p_r;
  logic p_dbz;
  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_done = 0; m_q = 0; m_r = 0; m_dbz = 0; m_ok = 1;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1; m_q = p_q; m_r = p_r; m_dbz = p_dbz; m_ok = 1;
        end
      end else if (start) begin
        p_q = (divisor == 0) ? {W{1'b1}} : dividend / divisor;
        p_r = (divisor == 0) ? dividend : dividend % divisor;
        p_dbz = ZC && (divisor == 0);
        m_ok = 0; m_dbz = 0;
        m_rem = p_dbz ? 0 : W;
        if (p_dbz) begin
          m_done = 1; m_q = p_q; m_r = p_r; m_dbz = 1; m_ok = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_rem > 0);
      chk("done", done, m_done);
      chk("div_by_zero", div_by_zero, m_dbz);
      if (m_ok) begin
        chk("quotient", quotient, m_q);
        chk("remainder", remainder, m_r);
      end
    end
  end

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int a, b, q, r;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);
    go(100, 7);
    chk("t1_busy_c1", busy, 1);
    wait_done(1, k);
    chk("t1_lat", k, 9);
    chk("t1_quot", quotient, 14);
    chk("t1_rem", remainder, 2);
    chk("t1_dbz", div_by_zero, 0);
    chk("t1_busy_done", busy, 0);
    @(negedge clk);
    go(255, 1);
    wait_done(1, k);
    chk("b2b_q1", quotient, 255);
    chk("b2b_r1", remainder, 0);
    go(5, 9);
    wait_done(1, k);
    chk("b2b_lat", k, 9);
    chk("b2b_q2", quotient, 0);
    chk("b2b_r2", remainder, 5);
    @(negedge clk);
    go(200, 0);
    wait_done(1, k);
    chk("dz_lat", k, ZC ? 1 : 9);
    chk("dz_quot", quotient, 255);
    chk("dz_rem", remainder, 200);
    chk("dz_flag", div_by_zero, ZC);
    @(negedge clk);
    go(100, 7);
    repeat (3) @(negedge clk);
    dividend = 9; divisor = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, k);
    chk("ign_lat", k, 9);
    chk("ign_quot", quotient, 14);
    chk("ign_rem", remainder, 2);
    @(negedge clk);
    go(200, 13);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quot", quotient, 0);
    chk("abort_rem", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    go(200, 13);
    wait_done(1, k);
    chk("fresh_quot", quotient, 15);
    chk("fresh_rem", remainder, 5);
    @(negedge clk);
    for (int i = 0; i < 500; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(1, 255);
      go(W'(a), W'(b));
      k = 1;
      if ($urandom_range(0, 3) == 0) begin
        for (int j = $urandom_range(1, 5); j > 0; j--) begin
          @(negedge clk);
          k++;
        end
        dividend = W'($urandom); divisor = W'($urandom); start = 1'b1;
        @(negedge clk);
        k++;
        start = 1'b0;
      end
      wait_done(k, k);
      chk("rand_lat", k, 9);
      q = int'(quotient);
      r = int'(remainder);
      chk("rand_identity", (q * b + r == a) && (r < b), 1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
